pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined RV32I core. It arbitrates four stall causes: data-memory wait, multicycle execute (mul/div), branch flush and load-use. Each cycle it drives one consistent set of per-stage write enables and bubble/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also tracks memory-wait timeout and stall/flush statistics; a timeout parks the core in a sticky halt.

---
 rtl/pipe_stall_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: prioritises memory wait,
// multicycle execute, branch flush and load-use into one set of stage controls.
module pipe_stall_ctrl #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RD,
  input  logic [4:0]  IF_ID_RS1,
  input  logic [4:0]  IF_ID_RS2,
  input  logic [6:0]  OP,
  input  logic        BrFlush,
  input  logic        ExBusy,
  input  logic        DMemReq,
  input  logic        DMemReady,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_CtrlSrc,
  output logic        EX_MEM_Write,
  output logic        EX_MEM_Valid,
  output logic        MEM_WB_Valid,
  output logic [1:0]  CtrlState,
  output logic        MemTimeout,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, EX_WAIT = 2'd2, HALT = 2'd3} state_t;

  typedef struct packed {
    logic pc, ifid_w, ifid_fl, idex_w, idex_src, exmem_w, exmem_v, memwb_v;
  } ctl_t;

  state_t          state, state_nxt;
  ctl_t            ctl;
  logic [CW-1:0]   wcnt;
  logic            use1, use2, lu, memstall, timeout;

  // Which source operands the ID instruction actually reads.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (OP)
      7'b1100011, 7'b0100011, 7'b0110011: begin use1 = 1'b1; use2 = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0010011: use1 = 1'b1;
      default: ;
    endcase
  end

  assign lu = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
              ((use1 && ID_EX_RD == IF_ID_RS1) || (use2 && ID_EX_RD == IF_ID_RS2));
  assign memstall = DMemReq && !DMemReady;
  assign timeout  = (state != HALT) && memstall && (wcnt == CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    ctl = '{pc: 1'b1, ifid_w: 1'b1, ifid_fl: 1'b0, idex_w: 1'b1, idex_src: 1'b1,
            exmem_w: 1'b1, exmem_v: 1'b1, memwb_v: 1'b1};
    if (!RSTn || state == HALT) begin
      ctl = '0;
    end else if (memstall) begin
      ctl.pc = 1'b0; ctl.ifid_w = 1'b0; ctl.idex_w = 1'b0; ctl.exmem_w = 1'b0;
      ctl.memwb_v = 1'b0;
    end else if (ExBusy) begin
      // EX keeps its op; downstream drains with a bubble behind it.
      ctl.pc = 1'b0; ctl.ifid_w = 1'b0; ctl.idex_w = 1'b0; ctl.exmem_v = 1'b0;
    end else if (BrFlush) begin
      ctl.ifid_fl = 1'b1; ctl.idex_src = 1'b0;
    end else if (lu) begin
      ctl.pc = 1'b0; ctl.ifid_w = 1'b0; ctl.idex_src = 1'b0;
    end
  end

  assign PCWrite       = ctl.pc;
  assign IF_ID_Write   = ctl.ifid_w;
  assign IF_ID_Flush   = ctl.ifid_fl;
  assign ID_EX_Write   = ctl.idex_w;
  assign ID_EX_CtrlSrc = ctl.idex_src;
  assign EX_MEM_Write  = ctl.exmem_w;
  assign EX_MEM_Valid  = ctl.exmem_v;
  assign MEM_WB_Valid  = ctl.memwb_v;
  assign CtrlState     = state;

  always_comb begin
    state_nxt = RUN;
    if (state == HALT || timeout) state_nxt = HALT;
    else if (memstall)            state_nxt = MEM_WAIT;
    else if (ExBusy)              state_nxt = EX_WAIT;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= RUN;
      wcnt       <= '0;
      MemTimeout <= 1'b0;
      StallCnt   <= '0;
      FlushCnt   <= '0;
    end else begin
      state <= state_nxt;
      if (!memstall)             wcnt <= '0;
      else if (state != HALT)    wcnt <= wcnt + 1'b1;
      if (timeout)               MemTimeout <= 1'b1;
      if (state != HALT && !ctl.pc && StallCnt != 16'hFFFF) StallCnt <= StallCnt + 1'b1;
      if (ctl.ifid_fl && FlushCnt != 16'hFFFF)              FlushCnt <= FlushCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Random + directed bench for pipe_stall_ctrl against a cause-priority model.
module tb_pipe_stall_ctrl;
  localparam int MW = 4;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic ID_EX_MemRead = 1'b0, BrFlush = 1'b0, ExBusy = 1'b0, DMemReq = 1'b0, DMemReady = 1'b0;
  logic [4:0] ID_EX_RD = '0, IF_ID_RS1 = '0, IF_ID_RS2 = '0;
  logic [6:0] OP = '0;
  logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_CtrlSrc;
  logic EX_MEM_Write, EX_MEM_Valid, MEM_WB_Valid, MemTimeout;
  logic [1:0] CtrlState;
  logic [15:0] StallCnt, FlushCnt;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit m_halt, m_to;
  int m_wcnt, m_stall, m_flush, m_state;

  pipe_stall_ctrl #(.MEM_WAIT_MAX(MW)) dut (
    .CLK(CLK), .RSTn(RSTn), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RD(ID_EX_RD),
    .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .OP(OP), .BrFlush(BrFlush),
    .ExBusy(ExBusy), .DMemReq(DMemReq), .DMemReady(DMemReady), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write),
    .ID_EX_CtrlSrc(ID_EX_CtrlSrc), .EX_MEM_Write(EX_MEM_Write), .EX_MEM_Valid(EX_MEM_Valid),
    .MEM_WB_Valid(MEM_WB_Valid), .CtrlState(CtrlState), .MemTimeout(MemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_set(input logic [6:0] op, input int which);
    logic [6:0] both [3] = '{7'b1100011, 7'b0100011, 7'b0110011};
    logic [6:0] one  [3] = '{7'b1100111, 7'b0000011, 7'b0010011};
    for (int i = 0; i < 3; i++)
      if ((which == 2 && op == both[i]) || (which == 1 && op == one[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_lu();
    if (!ID_EX_MemRead || ID_EX_RD == 0) return 1'b0;
    if (in_set(OP, 2)) return (ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2);
    if (in_set(OP, 1)) return ID_EX_RD == IF_ID_RS1;
    return 1'b0;
  endfunction

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, CtrlSrc, EX_MEM_Write, EX_MEM_Valid, MEM_WB_Valid}
  function automatic logic [7:0] m_out(input bit halted);
    if (!RSTn || halted)          return 8'b0000_0000;
    if (DMemReq && !DMemReady)    return 8'b0000_1010;
    if (ExBusy)                   return 8'b0000_1101;
    if (BrFlush)                  return 8'b1111_0111;
    if (m_lu())                   return 8'b0001_0111;
    return 8'b1101_1111;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_halt <= 1'b0; m_to <= 1'b0; m_wcnt <= 0; m_stall <= 0; m_flush <= 0; m_state <= 0;
    end else begin
      automatic logic [7:0] o = m_out(m_halt);
      automatic bit ms = DMemReq && !DMemReady;
      automatic bit tmo = !m_halt && ms && (m_wcnt == MW - 1);
      if (!m_halt && !o[7] && m_stall < 65535) m_stall <= m_stall + 1;
      if (o[5] && m_flush < 65535) m_flush <= m_flush + 1;
      if (!ms) m_wcnt <= 0;
      else if (!m_halt) m_wcnt <= m_wcnt + 1;
      if (tmo) begin m_to <= 1'b1; m_halt <= 1'b1; end
      m_state <= (m_halt || tmo) ? 3 : ms ? 1 : ExBusy ? 2 : 0;
    end
  end

  always @(negedge CLK) begin
    chk("ctl_vector", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_CtrlSrc,
                       EX_MEM_Write, EX_MEM_Valid, MEM_WB_Valid}, 32'(m_out(m_halt)));
    chk("ctrl_state", 32'(CtrlState), 32'(m_state));
    chk("mem_timeout", 32'(MemTimeout), 32'(m_to));
    chk("stall_cnt", 32'(StallCnt), 32'(m_stall));
    chk("flush_cnt", 32'(FlushCnt), 32'(m_flush));
  end

  task automatic idle();
    ID_EX_MemRead = 0; ID_EX_RD = 0; IF_ID_RS1 = 0; IF_ID_RS2 = 0; OP = 7'b0110111;
    BrFlush = 0; ExBusy = 0; DMemReq = 0; DMemReady = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #2 RSTn = 0; idle();
    @(negedge CLK); #2 RSTn = 1;
  endtask

  task automatic step();  // next cycle's inputs get driven just after this edge
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [6:0] ops [7] = '{7'b1100011, 7'b0100011, 7'b0110011, 7'b1100111,
                            7'b0000011, 7'b0010011, 7'b0110111};
    idle();
    #3;
    chk("reset_pc", 32'(PCWrite), 0);
    chk("reset_src", 32'(ID_EX_CtrlSrc), 0);
    do_reset();

    // load-use on RS2 of an R-type: single stall cycle
    step(); ID_EX_MemRead = 1; ID_EX_RD = 5; OP = 7'b0110011; IF_ID_RS1 = 1; IF_ID_RS2 = 5;
    @(negedge CLK);
    chk("lu_pc", 32'(PCWrite), 0); chk("lu_ifid", 32'(IF_ID_Write), 0);
    chk("lu_src", 32'(ID_EX_CtrlSrc), 0); chk("lu_idex", 32'(ID_EX_Write), 1);
    step(); idle();
    @(negedge CLK); chk("lu_cnt", 32'(StallCnt), 1); chk("lu_release", 32'(PCWrite), 1);
    step(); ID_EX_MemRead = 1; ID_EX_RD = 0; OP = 7'b0110011; IF_ID_RS2 = 0;
    @(negedge CLK); chk("rd0_nostall", 32'(PCWrite), 1);

    // branch flush beats load-use
    step(); ID_EX_RD = 5; IF_ID_RS1 = 5; BrFlush = 1;
    @(negedge CLK);
    chk("br_flush", 32'(IF_ID_Flush), 1); chk("br_src", 32'(ID_EX_CtrlSrc), 0);
    chk("br_pc", 32'(PCWrite), 1);
    step(); idle();
    @(negedge CLK); chk("br_fcnt", 32'(FlushCnt), 1); chk("br_scnt", 32'(StallCnt), 1);

    // four cycles of multicycle execute
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); ExBusy = 1;
      @(negedge CLK);
      chk("ex_pc", 32'(PCWrite), 0); chk("ex_emv", 32'(EX_MEM_Valid), 0);
      chk("ex_mwv", 32'(MEM_WB_Valid), 1);
      if (i > 0) chk("ex_state", 32'(CtrlState), 2);
    end
    step(); idle();
    @(negedge CLK); chk("ex_scnt", 32'(StallCnt), 4); chk("ex_done_pc", 32'(PCWrite), 1);

    // memory wait on top of ExBusy, then release into the ExBusy rules
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(); ExBusy = 1; DMemReq = 1; DMemReady = 0;
      @(negedge CLK);
      chk("mw_emw", 32'(EX_MEM_Write), 0); chk("mw_mwv", 32'(MEM_WB_Valid), 0);
      if (i > 0) chk("mw_state", 32'(CtrlState), 1);
    end
    step(); DMemReady = 1;
    @(negedge CLK);
    chk("mwr_emw", 32'(EX_MEM_Write), 1); chk("mwr_emv", 32'(EX_MEM_Valid), 0);
    chk("mwr_mwv", 32'(MEM_WB_Valid), 1); chk("mwr_pc", 32'(PCWrite), 0);
    step(); idle();
    @(negedge CLK); chk("mwr_state", 32'(CtrlState), 2); chk("mwr_to", 32'(MemTimeout), 0);

    // timeout after MW consecutive wait cycles -> sticky halt
    do_reset();
    step(); DMemReq = 1; DMemReady = 0;
    repeat (MW) step();
    DMemReady = 1;
    @(negedge CLK);
    chk("to_flag", 32'(MemTimeout), 1); chk("to_state", 32'(CtrlState), 3);
    chk("to_pc", 32'(PCWrite), 0); chk("to_emw", 32'(EX_MEM_Write), 0);
    step(); idle(); ExBusy = 1;
    @(negedge CLK); chk("halt_scnt", 32'(StallCnt), MW);
    do_reset();
    @(negedge CLK);
    chk("rec_state", 32'(CtrlState), 0); chk("rec_to", 32'(MemTimeout), 0);
    chk("rec_pc", 32'(PCWrite), 1);

    // saturation under a long ExBusy, then async reset mid-stall
    step(); ExBusy = 1;
    repeat (65540) @(posedge CLK);
    @(negedge CLK); chk("sat_scnt", 32'(StallCnt), 32'hFFFF);
    @(posedge CLK); #3 RSTn = 0; #1;
    chk("arst_emw", 32'(EX_MEM_Write), 0); chk("arst_mwv", 32'(MEM_WB_Valid), 0);
    chk("arst_scnt", 32'(StallCnt), 0); chk("arst_state", 32'(CtrlState), 0);
    #2 RSTn = 1;

    // randomized bursts, reset between so timeouts do not park the run
    for (int b = 0; b < 15; b++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        step();
        ID_EX_MemRead = 1'($urandom % 2);
        ID_EX_RD  = 5'($urandom_range(0, 3));
        IF_ID_RS1 = 5'($urandom_range(0, 3));
        IF_ID_RS2 = 5'($urandom_range(0, 3));
        OP        = ops[$urandom_range(0, 6)];
        BrFlush   = ($urandom % 6) == 0;
        ExBusy    = ($urandom % 5) == 0;
        DMemReq   = ($urandom % 3) == 0;
        DMemReady = ($urandom % 4) != 0;
      end
    end
    step(); idle();
    @(negedge CLK); @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
